// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: arbitrates REQ0/REQ1 and runs one APB transfer
// at a time, aborting with ERR when the slave holds PREADY low too long.
module apb_master_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WR0,
  input  logic                  WR1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic                  ERR,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      wait_cnt, wait_cnt_nx;
  logic                  gnt, gnt_nx;     // requester owning the transfer in flight
  logic                  prio, prio_nx;   // requester favoured on the next tie
  logic                  ack0_nx, ack1_nx, err_nx;
  logic                  psel_nx, penable_nx, pwrite_nx;
  logic [ADDR_WIDTH-1:0] paddr_nx;
  logic [DATA_WIDTH-1:0] pwdata_nx, rdata_nx;
  logic                  elig0, elig1, pick;

  // State and every output are flops; reset wins over all other inputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      gnt      <= 1'b0;
      prio     <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      ERR      <= 1'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      RDATA    <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      gnt      <= gnt_nx;
      prio     <= prio_nx;
      ACK0     <= ack0_nx;
      ACK1     <= ack1_nx;
      ERR      <= err_nx;
      PSEL     <= psel_nx;
      PENABLE  <= penable_nx;
      PWRITE   <= pwrite_nx;
      PADDR    <= paddr_nx;
      PWDATA   <= pwdata_nx;
      RDATA    <= rdata_nx;
    end
  end

  // A requester being acknowledged this cycle may not be re-granted yet.
  assign elig0 = REQ0 & ~ACK0;
  assign elig1 = REQ1 & ~ACK1;
  assign pick  = (elig0 & elig1) ? prio : elig1;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    gnt_nx      = gnt;
    prio_nx     = prio;
    ack0_nx     = 1'b0;
    ack1_nx     = 1'b0;
    err_nx      = 1'b0;
    psel_nx     = PSEL;
    penable_nx  = PENABLE;
    pwrite_nx   = PWRITE;
    paddr_nx    = PADDR;
    pwdata_nx   = PWDATA;
    rdata_nx    = RDATA;

    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt_nx     = pick;
          prio_nx    = ~pick;
          pwrite_nx  = pick ? WR1 : WR0;
          paddr_nx   = pick ? ADDR1 : ADDR0;
          pwdata_nx  = pick ? WDATA1 : WDATA0;
          psel_nx    = 1'b1;
          penable_nx = 1'b0;
          state_nx   = SETUP;
        end
      end
      SETUP: begin
        psel_nx     = 1'b1;
        penable_nx  = 1'b1;
        wait_cnt_nx = '0;
        state_nx    = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_nx   = IDLE;
          psel_nx    = 1'b0;
          penable_nx = 1'b0;
          ack0_nx    = ~gnt;
          ack1_nx    = gnt;
          if (!PWRITE) rdata_nx = PRDATA;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Slave stalled through the last permitted ACCESS cycle.
          state_nx   = IDLE;
          psel_nx    = 1'b0;
          penable_nx = 1'b0;
          ack0_nx    = ~gnt;
          ack1_nx    = gnt;
          err_nx     = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx   = IDLE;
        psel_nx    = 1'b0;
        penable_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: a slave model with programmable
// wait states, expected transfers queued at drive time and checked on ACK.
module tb_apb_master_arbiter;

  localparam int unsigned TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        REQ0, REQ1, WR0, WR1;
  logic [7:0]  ADDR0, ADDR1;
  logic [15:0] WDATA0, WDATA1;
  logic        ACK0, ACK1, ERR;
  logic [15:0] RDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [15:0] PWDATA, PRDATA;
  logic        PREADY;

  apb_master_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .ERR(ERR), .RDATA(RDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        id;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rdata;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          slv_wait = 0;
  logic [15:0] slv_rdata = '0;
  int          acc_cnt = 0;
  int          acc_seen = 0;
  logic [15:0] model_rdata = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: PREADY low for slv_wait ACCESS cycles, PRDATA only valid when ready.
  always @(posedge PCLK) begin
    if (PRESET || !(PSEL && PENABLE)) acc_cnt <= 0;
    else                             acc_cnt <= acc_cnt + 1;
  end
  assign PREADY = PSEL && PENABLE && (acc_cnt >= slv_wait);
  assign PRDATA = PREADY ? slv_rdata : 16'hDEAD;

  // Monitor: bus fields against the head of the scoreboard, completion on ACK.
  always @(negedge PCLK) begin
    if (PRESET) begin
      acc_seen = 0;
    end else begin
      if (PSEL) begin
        check_eq("sb_has_xfer", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check_eq("paddr", 32'(PADDR), 32'(exp_q[0].addr));
          check_eq("pwrite", 32'(PWRITE), 32'(exp_q[0].wr));
          check_eq("pwdata", 32'(PWDATA), 32'(exp_q[0].wdata));
        end
        if (PENABLE) acc_seen++;
      end
      if (ACK0 || ACK1) begin
        exp_t e;
        check_eq("ack_onehot", 32'(ACK0 & ACK1), 0);
        check_eq("sb_ack_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("ack_id", 32'(ACK1), 32'(e.id));
          check_eq("err", 32'(ERR), 32'(e.err));
          check_eq("rdata", 32'(RDATA), 32'(e.rdata));
          check_eq("access_cycles", 32'(acc_seen), 32'(e.acc));
        end
        acc_seen = 0;
      end
    end
  end

  task automatic push_exp(input logic id, input logic wr, input logic [7:0] addr,
                          input logic [15:0] wdata, input int waits, input logic [15:0] prd);
    exp_t e;
    logic to;
    to = (waits >= int'(TO));
    if (!wr && !to) model_rdata = prd;
    e.id = id; e.wr = wr; e.addr = addr; e.wdata = wdata; e.err = to;
    e.rdata = model_rdata; e.acc = to ? int'(TO) : waits + 1;
    exp_q.push_back(e);
  endtask

  // Entered and left on a negedge; optionally corrupts the request after grant.
  task automatic xfer(input logic id, input logic wr, input logic [7:0] addr,
                      input logic [15:0] wdata, input int waits, input logic [15:0] prd,
                      input int exp_lat, input bit scramble);
    int lat;
    bit got;
    slv_wait = waits; slv_rdata = prd;
    push_exp(id, wr, addr, wdata, waits, prd);
    if (id) begin REQ1 = 1; WR1 = wr; ADDR1 = addr; WDATA1 = wdata; end
    else    begin REQ0 = 1; WR0 = wr; ADDR0 = addr; WDATA0 = wdata; end
    lat = 0; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(posedge PCLK); #1;
      lat++;
      if (id ? ACK1 : ACK0) got = 1;
      if (scramble && lat == 1) begin
        if (id) begin REQ1 = 0; WR1 = ~wr; ADDR1 = ~addr; WDATA1 = ~wdata; end
        else    begin REQ0 = 0; WR0 = ~wr; ADDR0 = ~addr; WDATA0 = ~wdata; end
      end
    end
    check_eq("ack_seen", 32'(got), 1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    @(negedge PCLK);
    REQ0 = 0; REQ1 = 0;
    @(negedge PCLK);
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1;
    PRESET = 1; exp_q.delete(); model_rdata = '0;
    @(posedge PCLK); #1;
    PRESET = 0;
    @(negedge PCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacks, lat;
    bit got;
    PRESET = 1; REQ0 = 0; REQ1 = 0; WR0 = 0; WR1 = 0;
    ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check_eq("rst_psel", 32'(PSEL), 0);
    check_eq("rst_penable", 32'(PENABLE), 0);
    check_eq("rst_pwrite", 32'(PWRITE), 0);
    check_eq("rst_paddr", 32'(PADDR), 0);
    check_eq("rst_pwdata", 32'(PWDATA), 0);
    check_eq("rst_rdata", 32'(RDATA), 0);
    check_eq("rst_acks", 32'({ACK0, ACK1, ERR}), 0);
    @(negedge PCLK);
    PRESET = 0;
    @(negedge PCLK);

    xfer(1'b0, 1'b1, 8'h00, 16'hFFFF, 0, 16'h0000, 3, 1'b0);
    xfer(1'b1, 1'b0, 8'h01, 16'h0000, 2, 16'hEACF, 5, 1'b0);
    check_eq("rdata_after_read", 32'(RDATA), 32'h0000EACF);
    xfer(1'b1, 1'b1, 8'h5A, 16'h1357, 0, 16'h0000, 3, 1'b1);

    // Both requesters held high from reset: grants must alternate 0,1,0,1.
    do_reset();
    slv_wait = 0;
    ADDR0 = 8'h10; WDATA0 = 16'hA000; WR0 = 1;
    ADDR1 = 8'h20; WDATA1 = 16'hB111; WR1 = 1;
    for (int i = 0; i < 4; i++)
      push_exp(1'(i % 2), 1'b1, (i % 2) ? 8'h20 : 8'h10, (i % 2) ? 16'hB111 : 16'hA000, 0, 16'h0);
    REQ0 = 1; REQ1 = 1;
    nacks = 0;
    for (int c = 0; c < 200 && nacks < 4; c++) begin
      @(posedge PCLK); #1;
      if (ACK0 || ACK1) nacks++;
    end
    check_eq("contention_acks", 32'(nacks), 4);
    @(negedge PCLK);
    REQ0 = 0; REQ1 = 0;
    @(negedge PCLK);

    xfer(1'b1, 1'b0, 8'h02, 16'h0000, 0, 16'h0A5C, 3, 1'b0);
    xfer(1'b0, 1'b0, 8'h03, 16'h0000, 16, 16'hBEEF, 2 + int'(TO), 1'b0);
    check_eq("rdata_kept_on_timeout", 32'(RDATA), 32'h00000A5C);
    xfer(1'b0, 1'b0, 8'h04, 16'h0000, 15, 16'h7E57, 2 + int'(TO), 1'b0);

    // Reset in the middle of a stalled ACCESS, then a tie won by requester 0.
    slv_wait = 1000;
    push_exp(1'b0, 1'b1, 8'h44, 16'h4444, 1000, 16'h0);
    REQ0 = 1; WR0 = 1; ADDR0 = 8'h44; WDATA0 = 16'h4444;
    repeat (6) @(posedge PCLK);
    #1;
    check_eq("in_access", 32'({PSEL, PENABLE}), 32'h3);
    PRESET = 1; exp_q.delete(); model_rdata = '0;
    REQ1 = 1; WR1 = 0; ADDR1 = 8'h55;
    @(posedge PCLK); #1;
    check_eq("midrst_ctrl", 32'({PSEL, PENABLE, PWRITE}), 0);
    check_eq("midrst_bus", 32'({PADDR, PWDATA}), 0);
    check_eq("midrst_acks", 32'({ACK0, ACK1, ERR}), 0);
    check_eq("midrst_rdata", 32'(RDATA), 0);
    slv_wait = 0;
    ADDR0 = 8'h33; WDATA0 = 16'h1234;
    push_exp(1'b0, 1'b1, 8'h33, 16'h1234, 0, 16'h0);
    PRESET = 0;
    lat = 0; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(posedge PCLK); #1;
      lat++;
      if (ACK0 || ACK1) got = 1;
    end
    check_eq("post_rst_ack0", 32'({ACK1, ACK0}), 32'h1);
    check_eq("post_rst_latency", 32'(lat), 3);
    @(negedge PCLK);
    REQ0 = 0; REQ1 = 0;
    repeat (3) @(negedge PCLK);
    check_eq("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 Parameter DATA_WIDTH, default 16, APB data width.
REQ-003 Parameter TIMEOUT, default 16, number of ACCESS cycles without PREADY before the transfer is aborted; legal range 2-255.
REQ-004 PCLK  input  1  single clock; all state changes on rising edge.
REQ-005 PRESET  input  1  reset, synchronous, active-high.
REQ-006 REQ0, REQ1  input  1 each  transfer request from requester 0 and requester 1.
REQ-007 WR0, WR1  input  1 each  direction per requester: 1=write, 0=read.
REQ-008 ADDR0, ADDR1  input  ADDR_WIDTH each  transfer address per requester.
REQ-009 WDATA0, WDATA1  input  DATA_WIDTH each  write data per requester.
REQ-010 ACK0, ACK1  output  1 each  one-cycle completion pulse per requester.
REQ-011 ERR  output  1  one-cycle pulse, coincident with ACKn, flagging a timeout abort.
REQ-012 RDATA  output  DATA_WIDTH  registered read data from the last successful read.
REQ-013 PSEL, PENABLE, PWRITE  output  1 each  APB control to the slave.
REQ-014 PADDR  output  ADDR_WIDTH  APB address; PWDATA  output  DATA_WIDTH  APB write data.
REQ-015 PRDATA  input  DATA_WIDTH  APB read data; PREADY  input  1  APB slave ready.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-017 IDLE: PSEL=0, PENABLE=0; if any eligible REQn=1, grant one requester, latch its WRn/ADDRn/WDATAn into PWRITE/PADDR/PWDATA and go to SETUP; otherwise stay in IDLE.
REQ-018 Arbitration: single request is granted directly; if both request, grant the requester not granted most recently; after reset requester 0 wins the first tie.
REQ-019 In the IDLE cycle where ACKn=1, REQn SHALL be ignored (ineligible); requesters drop REQn on the cycle after ACKn.
REQ-020 SETUP: PSEL=1, PENABLE=0, lasting exactly one cycle, then unconditionally ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL stay stable from SETUP until return to IDLE.
REQ-022 ACCESS with PREADY=1: next cycle go to IDLE with ACKn=1 for the granted requester; on a read, RDATA SHALL be loaded with PRDATA sampled in that ACCESS cycle; on a write, RDATA is unchanged.
REQ-023 Wait counter SHALL reset to 0 on entering ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-024 If PREADY=0 in the TIMEOUT-th consecutive ACCESS cycle: go to IDLE, pulse ACKn and ERR together, RDATA unchanged.
REQ-025 PREADY=1 in the TIMEOUT-th ACCESS cycle SHALL count as success (ERR=0).
REQ-026 Minimum REQn-to-ACKn latency with zero wait states SHALL be 3 cycles (IDLE sample, SETUP, ACCESS; ACKn in following cycle).
REQ-027 Deassertion of REQn or changes to ADDRn/WDATAn/WRn after grant SHALL NOT affect the transfer in flight.
REQ-028 ACK0 and ACK1 SHALL never be high in the same cycle; at most one transfer is in flight.

Reset
REQ-029 PRESET=1 at a rising edge SHALL force IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, RDATA=0, ACK0=ACK1=ERR=0, wait counter 0, tie pointer to requester 0.
REQ-030 Reset asserted during SETUP or ACCESS SHALL abort the transfer with no ACKn or ERR issued.
REQ-031 PRESET has priority over every other input in the same cycle.

Verification
REQ-032 Write: REQ0=1, WR0=1, ADDR0=0x00, WDATA0=0xFFFF, PREADY=1 -> PSEL 1 cycle before PENABLE, PADDR=0x00, PWDATA=0xFFFF, ACK0 on cycle 3, ERR=0.
REQ-033 Read: REQ1=1, WR1=0, ADDR1=0x01, slave PRDATA=0xEACF, PREADY low for 2 ACCESS cycles -> ACK1 after 5 cycles, RDATA=0xEACF.
REQ-034 Contention: REQ0 and REQ1 held high continuously after reset -> grants alternate 0,1,0,1; each ACK one cycle wide; no back-to-back re-grant of the same requester.
REQ-035 Timeout: PREADY held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then ACKn=1 and ERR=1 same cycle, RDATA unchanged; repeat with PREADY=1 on cycle 16 -> ERR=0.
REQ-036 Reset in ACCESS: assert PRESET for one cycle mid-wait -> next cycle all outputs at reset values, no ACK/ERR, subsequent REQ0 transfer completes normally with requester 0 winning a tie.
